// File: rtl/conv_mem_host_if.sv
// Bus between the CONV engine / host and the conv_mem_host memory responder.
interface conv_mem_host_if #(
    parameter int unsigned DW = 20,
    parameter int unsigned AW = 12
);
    // image load stream
    logic          ld_valid;
    logic [DW-1:0] ld_data;
    logic          ld_ready;
    // engine handshake
    logic          ready;
    logic          busy;
    logic          done;
    // image read port
    logic [AW-1:0] iaddr;
    logic [DW-1:0] idata;
    // layer memory write/read ports
    logic          cwr;
    logic [AW-1:0] caddr_wr;
    logic [DW-1:0] cdata_wr;
    logic          crd;
    logic [AW-1:0] caddr_rd;
    logic [DW-1:0] cdata_rd;
    logic [2:0]    csel;
    // host readback and status
    logic [1:0]    rb_sel;
    logic [AW-1:0] rb_addr;
    logic [DW-1:0] rb_data;
    logic [12:0]   l0_wr_cnt;
    logic [10:0]   l1_wr_cnt;
    logic          err;

    // memory responder side
    modport slave (
        input  ld_valid, ld_data, busy, iaddr, cwr, caddr_wr, cdata_wr,
               crd, caddr_rd, csel, rb_sel, rb_addr,
        output ld_ready, ready, done, idata, cdata_rd, rb_data,
               l0_wr_cnt, l1_wr_cnt, err
    );

    // engine / host side
    modport master (
        output ld_valid, ld_data, busy, iaddr, cwr, caddr_wr, cdata_wr,
               crd, caddr_rd, csel, rb_sel, rb_addr,
        input  ld_ready, ready, done, idata, cdata_rd, rb_data,
               l0_wr_cnt, l1_wr_cnt, err
    );
endinterface

// File: rtl/conv_mem_host.sv
// Memory responder for the CONV engine: image ROM, layer-0 and layer-1 memories,
// load/ready/run/done sequencing, write counters and sticky protocol error.
module conv_mem_host #(
    parameter int unsigned DW        = 20,
    parameter int unsigned AW        = 12,
    parameter int unsigned IMG_DEPTH = 4096,
    parameter int unsigned L0_DEPTH  = 4096,
    parameter int unsigned L1_DEPTH  = 1024
) (
    input  logic            clk,
    input  logic            reset,
    conv_mem_host_if.slave  bus
);
    localparam int unsigned PW    = $clog2(IMG_DEPTH);
    localparam int unsigned L1_AW = $clog2(L1_DEPTH);
    localparam int unsigned C0W   = 13;
    localparam int unsigned C1W   = 11;

    typedef enum logic [1:0] {S_LOAD, S_READY, S_RUN, S_DONE} state_t;

    logic [DW-1:0] img_mem [IMG_DEPTH];
    logic [DW-1:0] l0_mem  [L0_DEPTH];
    logic [DW-1:0] l1_mem  [L1_DEPTH];

    state_t         state_q;
    logic [PW-1:0]  ptr_q;
    logic           ready_q;
    logic           done_q;
    logic           ld_ready_q;
    logic           err_q;
    logic [C0W-1:0] l0_cnt_q, l0_cnt_d;
    logic [C1W-1:0] l1_cnt_q, l1_cnt_d;

    logic sel_l0, sel_l1, mapped;
    logic l1_wr_oob, l1_rd_oob;
    logic l0_wr_ok, l1_wr_ok, ld_accept;
    logic err_set_c;
    logic [PW-1:0]  img_wr_addr;
    logic [DW-1:0]  cdata_rd_c;
    logic [DW-1:0]  rb_data_c;

    // Address decode and protocol checks for the engine-side ports
    always_comb begin
        sel_l0    = (bus.csel == 3'b001);
        sel_l1    = (bus.csel == 3'b011);
        mapped    = sel_l0 | sel_l1;
        l1_wr_oob = (32'(bus.caddr_wr) >= L1_DEPTH);
        l1_rd_oob = (32'(bus.caddr_rd) >= L1_DEPTH);
        l0_wr_ok  = bus.cwr & sel_l0;
        l1_wr_ok  = bus.cwr & sel_l1 & ~l1_wr_oob;
        ld_accept = bus.ld_valid & ld_ready_q;
        // a load accepted in S_DONE always starts a new image at word 0
        img_wr_addr = (state_q == S_DONE) ? '0 : ptr_q;
        err_set_c = ((bus.cwr | bus.crd) & ~mapped)
                  | (bus.cwr & sel_l1 & l1_wr_oob)
                  | (bus.crd & sel_l1 & l1_rd_oob)
                  | ((bus.cwr | bus.crd) & (state_q != S_RUN));
    end

    // Saturating write counters, next value
    always_comb begin
        l0_cnt_d = l0_cnt_q;
        l1_cnt_d = l1_cnt_q;
        if (l0_wr_ok && (l0_cnt_q != '1)) begin
            l0_cnt_d = l0_cnt_q + C0W'(1);
        end
        if (l1_wr_ok && (l1_cnt_q != '1)) begin
            l1_cnt_d = l1_cnt_q + C1W'(1);
        end
    end

    // Combinational engine read of the selected layer memory
    always_comb begin
        cdata_rd_c = '0;
        if (bus.crd) begin
            if (sel_l0) begin
                cdata_rd_c = l0_mem[bus.caddr_rd];
            end else if (sel_l1 && !l1_rd_oob) begin
                cdata_rd_c = l1_mem[bus.caddr_rd[L1_AW-1:0]];
            end
        end
    end

    // Combinational host readback mux
    always_comb begin
        rb_data_c = '0;
        case (bus.rb_sel)
            2'd0:    rb_data_c = img_mem[bus.rb_addr];
            2'd1:    rb_data_c = l0_mem[bus.rb_addr];
            2'd2:    rb_data_c = l1_mem[bus.rb_addr[L1_AW-1:0]];
            default: rb_data_c = '0;
        endcase
    end

    // Memory writes; contents survive reset
    always_ff @(posedge clk) begin
        if (ld_accept) begin
            img_mem[img_wr_addr] <= bus.ld_data;
        end
        if (l0_wr_ok) begin
            l0_mem[bus.caddr_wr] <= bus.cdata_wr;
        end
        if (l1_wr_ok) begin
            l1_mem[bus.caddr_wr[L1_AW-1:0]] <= bus.cdata_wr;
        end
    end

    // Sequencing FSM with registered handshake outputs, counters and sticky error
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_LOAD;
            ptr_q      <= '0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            ld_ready_q <= 1'b1;
            err_q      <= 1'b0;
            l0_cnt_q   <= '0;
            l1_cnt_q   <= '0;
        end else begin
            err_q    <= err_q | err_set_c;
            l0_cnt_q <= l0_cnt_d;
            l1_cnt_q <= l1_cnt_d;
            case (state_q)
                S_LOAD: begin
                    if (bus.ld_valid) begin
                        ptr_q <= ptr_q + PW'(1);
                        if (ptr_q == PW'(IMG_DEPTH - 1)) begin
                            state_q    <= S_READY;
                            ready_q    <= 1'b1;
                            ld_ready_q <= 1'b0;
                        end
                    end
                end
                S_READY: begin
                    if (bus.busy) begin
                        state_q  <= S_RUN;
                        ready_q  <= 1'b0;
                        // a new run starts its counters from zero
                        l0_cnt_q <= '0;
                        l1_cnt_q <= '0;
                    end
                end
                S_RUN: begin
                    if (!bus.busy) begin
                        state_q    <= S_DONE;
                        done_q     <= 1'b1;
                        ld_ready_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.ld_valid) begin
                        state_q <= S_LOAD;
                        ptr_q   <= PW'(1);
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_LOAD;
                end
            endcase
        end
    end

    assign bus.ld_ready  = ld_ready_q;
    assign bus.ready     = ready_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.l0_wr_cnt = l0_cnt_q;
    assign bus.l1_wr_cnt = l1_cnt_q;
    assign bus.idata     = img_mem[bus.iaddr];
    assign bus.cdata_rd  = cdata_rd_c;
    assign bus.rb_data   = rb_data_c;

endmodule

// File: tb/tb_conv_mem_host.sv
// Self-checking bench for conv_mem_host: reference memories plus a read scoreboard.
module tb_conv_mem_host;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    conv_mem_host_if bus ();
    conv_mem_host dut (.clk(clk), .reset(reset), .bus(bus));

    logic [19:0] img_m [4096];
    logic [19:0] l0_m  [4096];
    logic [19:0] l1_m  [1024];
    int          mptr;
    int          l0_cnt_m;
    int          l1_cnt_m;

    logic [19:0] exp_q [$];
    string       tag_q [$];
    int          n_chk  = 0;
    int          n_fail = 0;

    // single comparison point
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [19:0] exp);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
    endtask

    task automatic pop_cmp(input logic [19:0] obs);
        logic [19:0] e;
        string       t;
        check("sb_depth", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check(t, 32'(obs), 32'(e));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.ld_valid = 1'b0; bus.ld_data = '0; bus.busy = 1'b0;
        bus.iaddr = '0; bus.cwr = 1'b0; bus.caddr_wr = '0; bus.cdata_wr = '0;
        bus.crd = 1'b0; bus.caddr_rd = '0; bus.csel = 3'b000;
        bus.rb_sel = 2'd3; bus.rb_addr = '0;
    endtask

    task automatic load_word(input logic [19:0] d);
        bus.ld_valid = 1'b1;
        bus.ld_data  = d;
        step();
        img_m[mptr] = d;
        mptr = (mptr + 1) % 4096;
        bus.ld_valid = 1'b0;
    endtask

    task automatic wr(input logic [2:0] sel, input logic [11:0] a, input logic [19:0] d);
        bus.csel = sel; bus.cwr = 1'b1; bus.caddr_wr = a; bus.cdata_wr = d;
        step();
        if (sel == 3'b001) begin
            l0_m[a] = d; l0_cnt_m++;
        end else if (sel == 3'b011 && a < 12'd1024) begin
            l1_m[a[9:0]] = d; l1_cnt_m++;
        end
        bus.cwr = 1'b0;
    endtask

    task automatic rb_check(input string tag, input logic [1:0] sel, input logic [11:0] a,
                            input logic [19:0] exp);
        bus.rb_sel = sel; bus.rb_addr = a;
        push(tag, exp);
        #1;
        pop_cmp(bus.rb_data);
    endtask

    task automatic status(input string tag, input logic lr, input logic rdy,
                          input logic dn, input logic er);
        check({tag, "_ld_ready"}, 32'(bus.ld_ready), 32'(lr));
        check({tag, "_ready"},    32'(bus.ready),    32'(rdy));
        check({tag, "_done"},     32'(bus.done),     32'(dn));
        check({tag, "_err"},      32'(bus.err),      32'(er));
    endtask

    initial begin
        idle();
        mptr = 0; l0_cnt_m = 0; l1_cnt_m = 0;
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        status("rst", 1'b1, 1'b0, 1'b0, 1'b0);
        check("rst_l0cnt", 32'(bus.l0_wr_cnt), 32'd0);
        check("rst_l1cnt", 32'(bus.l1_wr_cnt), 32'd0);

        // full image load img[a] = a
        for (int a = 0; a < 4096; a++) begin
            if (a == 0 || a == 4095) check("load_ld_ready", 32'(bus.ld_ready), 32'd1);
            load_word(20'(a));
        end
        status("loaded", 1'b0, 1'b1, 1'b0, 1'b0);
        rb_check("rb_img_0ff", 2'd0, 12'h0FF, img_m[12'h0FF]);
        check("rb_img_const", 32'(bus.rb_data), 32'h000FF);

        // start run
        bus.busy = 1'b1;
        step();
        status("run", 1'b0, 1'b0, 1'b0, 1'b0);
        check("run_l0cnt", 32'(bus.l0_wr_cnt), 32'd0);
        check("run_l1cnt", 32'(bus.l1_wr_cnt), 32'd0);
        bus.iaddr = 12'h041;
        push("idata_041", img_m[12'h041]);
        #1;
        pop_cmp(bus.idata);

        // L0 write then read-back
        wr(3'b001, 12'h123, 20'h1310A);
        bus.csel = 3'b001; bus.crd = 1'b1; bus.caddr_rd = 12'h123;
        push("l0_rd_123", l0_m[12'h123]);
        #1;
        pop_cmp(bus.cdata_rd);
        check("l0_cnt_1", 32'(bus.l0_wr_cnt), 32'(l0_cnt_m));

        // same-cycle read of a location being written returns old data
        bus.cwr = 1'b1; bus.caddr_wr = 12'h123; bus.cdata_wr = 20'h22222;
        push("l0_rd_old", l0_m[12'h123]);
        #1;
        pop_cmp(bus.cdata_rd);
        step();
        l0_m[12'h123] = 20'h22222; l0_cnt_m++;
        bus.cwr = 1'b0;
        push("l0_rd_new", l0_m[12'h123]);
        #1;
        pop_cmp(bus.cdata_rd);
        bus.crd = 1'b0;
        check("l0_cnt_2", 32'(bus.l0_wr_cnt), 32'(l0_cnt_m));

        // L1 writes, readback and engine read
        wr(3'b011, 12'h000, 20'h0BEEF);
        wr(3'b011, 12'h3FF, 20'h0ABCD);
        rb_check("rb_l1_3ff", 2'd2, 12'h3FF, l1_m[10'h3FF]);
        check("l1_cnt", 32'(bus.l1_wr_cnt), 32'(l1_cnt_m));
        bus.csel = 3'b011; bus.crd = 1'b1; bus.caddr_rd = 12'h3FF;
        push("l1_rd_3ff", l1_m[10'h3FF]);
        #1;
        pop_cmp(bus.cdata_rd);
        step();
        bus.crd = 1'b0;
        check("legal_err", 32'(bus.err), 32'd0);

        // L1 out-of-range write: err, no write, no count
        wr(3'b011, 12'h400, 20'h77777);
        check("oob_err", 32'(bus.err), 32'd1);
        check("oob_l1cnt", 32'(bus.l1_wr_cnt), 32'(l1_cnt_m));
        rb_check("oob_l1_0", 2'd2, 12'h000, l1_m[10'h000]);

        // run ends
        bus.busy = 1'b0;
        step();
        status("done", 1'b1, 1'b0, 1'b1, 1'b1);

        // new image starts from S_DONE, then reset mid-load
        for (int i = 0; i < 100; i++) begin
            load_word(20'h50000 + 20'(i));
            if (i == 0) check("done_cleared", 32'(bus.done), 32'd0);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        mptr = 0;
        status("midrst", 1'b1, 1'b0, 1'b0, 1'b0);
        check("midrst_l0cnt", 32'(bus.l0_wr_cnt), 32'd0);
        load_word(20'hAAAAA);
        rb_check("reload_img0", 2'd0, 12'h000, img_m[0]);
        rb_check("reload_img1", 2'd0, 12'h001, img_m[1]);
        for (int a = 1; a < 4096; a++) load_word(20'(a * 3));
        status("reloaded", 1'b0, 1'b1, 1'b0, 1'b0);

        // second run: unmapped csel
        bus.busy = 1'b1;
        step();
        l0_cnt_m = 0; l1_cnt_m = 0;
        bus.iaddr = 12'h005;
        push("idata2_005", img_m[5]);
        #1;
        pop_cmp(bus.idata);
        bus.csel = 3'b010; bus.cwr = 1'b1; bus.caddr_wr = 12'h123; bus.cdata_wr = 20'hFFFFF;
        bus.crd = 1'b1; bus.caddr_rd = 12'h123;
        push("unmapped_rd", 20'h0);
        #1;
        pop_cmp(bus.cdata_rd);
        step();
        bus.cwr = 1'b0; bus.crd = 1'b0;
        check("unmapped_err", 32'(bus.err), 32'd1);
        check("unmapped_l0cnt", 32'(bus.l0_wr_cnt), 32'(l0_cnt_m));
        check("unmapped_l1cnt", 32'(bus.l1_wr_cnt), 32'(l1_cnt_m));
        rb_check("unmapped_l0_123", 2'd1, 12'h123, l0_m[12'h123]);
        rb_check("rb_none", 2'd3, 12'h123, 20'h0);
        bus.busy = 1'b0;
        step();
        status("done2", 1'b1, 1'b0, 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
